rvvi_stall_scheduler: RTL and testbench

- Schedules all CPU stall episodes for the RVVI trace path.
- Arbitrates two stall requesters:
  - host slow-down requests, arriving as Ethernet control frames;
  - local trace-FIFO almost-full.
- Sequences each episode: wait for frame-boundary acknowledge, hold, mandatory cooldown.
- Configures host-hold duration adaptively from reported host FIFO fill. Drives the single HostStall into the RVVI/core stall logic.

---
 rtl/rvvi_stall_scheduler.sv | 143 ++++++++++++++
 tb/tb_rvvi_stall_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvvi_stall_scheduler.sv
// Stall scheduler for the RVVI trace path: arbitrates host slow-down requests against
// local trace-FIFO almost-full. Optional statistics counters are enabled by RVVI_STALL_STATS_EN.
module rvvi_stall_scheduler #(
  parameter int unsigned BASE_COUNT = 800,
  parameter int unsigned MAX_SHIFT  = 6,
  parameter int unsigned CNT_W      = 17,
  parameter int unsigned PEND_W     = 10,
  parameter int unsigned COOLDOWN   = 16
) (
  input  logic              CPUCLK,
  input  logic              bus_struct_reset,
  input  logic              HostRequestSlowDown,
  input  logic [31:0]       HostFiFoFillAmt,
  input  logic              LocalFifoAlmostFull,
  input  logic              RVVIStall,
  output logic              HostStall,
  output logic [1:0]        StallReason,
  output logic [PEND_W-1:0] PendingCount
`ifdef RVVI_STALL_STATS_EN
  ,
  output logic [31:0]       StallCycles,
  output logic [15:0]       StallEpisodes
`endif
);

  localparam int unsigned COOL_W = $clog2(COOLDOWN + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_ACK   = 3'd1,
    HOLD_HOST  = 3'd2,
    HOLD_LOCAL = 3'd3,
    COOL_DOWN  = 3'd4
  } state_t;

  state_t              state, nextState;
  logic                reqDly;
  logic                hostEdge;
  logic [CNT_W-1:0]    holdCnt;
  logic [CNT_W-1:0]    threshold;
  logic [CNT_W-1:0]    holdTarget;
  logic [COOL_W-1:0]   coolCnt;
  logic [3:0]          fillShift;
  logic                holdDone;
  logic                coolDone;
  logic                unusedFillLow;

  assign hostEdge      = HostRequestSlowDown & ~reqDly;
  assign unusedFillLow = ^HostFiFoFillAmt[23:0];

  // Hold length scales with the magnitude of the host fill byte: one doubling per bit position.
  always_comb begin
    fillShift = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (HostFiFoFillAmt[24 + i]) fillShift = 4'(i + 1);
    end
    if (fillShift > 4'(MAX_SHIFT)) fillShift = 4'(MAX_SHIFT);
  end

  assign holdTarget = CNT_W'(BASE_COUNT) << fillShift;
  assign holdDone   = (state == HOLD_HOST) && (holdCnt == threshold - CNT_W'(1));
  assign coolDone   = (coolCnt == COOL_W'(COOLDOWN - 1));

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (LocalFifoAlmostFull)                        nextState = HOLD_LOCAL;
        else if (hostEdge || (PendingCount != '0))      nextState = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (LocalFifoAlmostFull)                        nextState = HOLD_LOCAL;
        else if (RVVIStall)                             nextState = HOLD_HOST;
      end
      HOLD_HOST: begin
        // A local request raised during the host hold follows it directly, without a cooldown gap.
        if (holdDone) nextState = LocalFifoAlmostFull ? HOLD_LOCAL : COOL_DOWN;
      end
      HOLD_LOCAL: begin
        if (!LocalFifoAlmostFull)                       nextState = COOL_DOWN;
      end
      COOL_DOWN: begin
        if (LocalFifoAlmostFull)                        nextState = HOLD_LOCAL;
        else if (coolDone)                              nextState = IDLE;
      end
      default:                                          nextState = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CPUCLK or posedge bus_struct_reset) begin
    if (bus_struct_reset) begin
      state        <= IDLE;
      reqDly       <= 1'b0;
      PendingCount <= '0;
      holdCnt      <= '0;
      threshold    <= '0;
      coolCnt      <= '0;
    end else begin
      state  <= nextState;
      reqDly <= HostRequestSlowDown;

      case ({hostEdge, holdDone})
        2'b10:   if (PendingCount != '1) PendingCount <= PendingCount + 1'b1;
        2'b01:   if (PendingCount != '0) PendingCount <= PendingCount - 1'b1;
        default: PendingCount <= PendingCount;
      endcase

      // Threshold is frozen at hold entry; later fill reports do not stretch the current hold.
      if (state == WAIT_ACK && nextState == HOLD_HOST) begin
        holdCnt   <= '0;
        threshold <= holdTarget;
      end else if (state == HOLD_HOST) begin
        holdCnt <= holdCnt + 1'b1;
      end

      coolCnt <= (state == COOL_DOWN) ? coolCnt + 1'b1 : '0;
    end
  end

  assign HostStall   = (state == HOLD_HOST) || (state == HOLD_LOCAL);
  assign StallReason = (state == HOLD_HOST)  ? 2'b01 :
                       (state == HOLD_LOCAL) ? 2'b10 : 2'b00;

`ifdef RVVI_STALL_STATS_EN
  logic enterHold;

  assign enterHold = ((nextState == HOLD_HOST)  && (state != HOLD_HOST)) ||
                     ((nextState == HOLD_LOCAL) && (state != HOLD_LOCAL));

  always_ff @(posedge CPUCLK or posedge bus_struct_reset) begin
    if (bus_struct_reset) begin
      StallCycles   <= '0;
      StallEpisodes <= '0;
    end else begin
      if (HostStall && (StallCycles != '1))   StallCycles   <= StallCycles + 1'b1;
      if (enterHold && (StallEpisodes != '1)) StallEpisodes <= StallEpisodes + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rvvi_stall_scheduler.sv
// Directed bench for rvvi_stall_scheduler: a monitor measures every stall episode
// (reason, length) and compares it against a queue of expected episodes.
module tb_rvvi_stall_scheduler;

  localparam int unsigned BASE  = 800;
  localparam int unsigned COOL  = 16;
  // Low cycles between back-to-back episodes: cooldown, one IDLE cycle, one WAIT_ACK cycle.
  localparam int unsigned GAP   = COOL + 2;

  logic        CPUCLK;
  logic        bus_struct_reset;
  logic        HostRequestSlowDown;
  logic [31:0] HostFiFoFillAmt;
  logic        LocalFifoAlmostFull;
  logic        RVVIStall;
  logic        HostStall;
  logic [1:0]  StallReason;
  logic [9:0]  PendingCount;
`ifdef RVVI_STALL_STATS_EN
  logic [31:0] StallCycles;
  logic [15:0] StallEpisodes;
`endif

  rvvi_stall_scheduler dut (
    .CPUCLK              (CPUCLK),
    .bus_struct_reset    (bus_struct_reset),
    .HostRequestSlowDown (HostRequestSlowDown),
    .HostFiFoFillAmt     (HostFiFoFillAmt),
    .LocalFifoAlmostFull (LocalFifoAlmostFull),
    .RVVIStall           (RVVIStall),
    .HostStall           (HostStall),
    .StallReason         (StallReason),
    .PendingCount        (PendingCount)
`ifdef RVVI_STALL_STATS_EN
    ,
    .StallCycles         (StallCycles),
    .StallEpisodes       (StallEpisodes)
`endif
  );

  initial CPUCLK = 1'b0;
  always #5 CPUCLK = ~CPUCLK;

  typedef struct {
    logic [1:0] reason;
    int         len;
  } ep_t;

  ep_t sbq[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_ep(input logic [1:0] r, input int len);
    ep_t e;
    e.reason = r;
    e.len    = len;
    sbq.push_back(e);
  endtask

  task automatic end_episode(input logic [1:0] r, input int len);
    ep_t e;
    check("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      check("ep_reason", 32'(r), 32'(e.reason));
      check("ep_len", 32'(len), 32'(e.len));
    end
  endtask

  // Episode monitor: samples 2 time units after each rising edge.
  logic [1:0] runReason = 2'b00;
  int         runLen    = 0;

  always @(posedge CPUCLK) begin
    #2;
    if (bus_struct_reset) begin
      runReason = 2'b00;
      runLen    = 0;
    end else begin
      check("stall_vs_reason", 32'(HostStall), 32'(StallReason != 2'b00));
      if (StallReason !== runReason) begin
        if (runReason != 2'b00) end_episode(runReason, runLen);
        runReason = StallReason;
        runLen    = 1;
      end else begin
        runLen++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CPUCLK);
  endtask

  task automatic pulse();
    HostRequestSlowDown = 1'b1;
    cyc(1);
    HostRequestSlowDown = 1'b0;
  endtask

  task automatic wait_stall(input string tag, input logic lvl, input int budget, output int n);
    n = 0;
    while (HostStall !== lvl && n < budget) begin
      @(negedge CPUCLK);
      n++;
    end
    check(tag, 32'(HostStall), 32'(lvl));
  endtask

  task automatic wait_reason(input string tag, input logic [1:0] r, input int budget, output int n);
    n = 0;
    while (StallReason !== r && n < budget) begin
      @(negedge CPUCLK);
      n++;
    end
    check(tag, 32'(StallReason), 32'(r));
  endtask

  initial begin
    int n;
    bus_struct_reset    = 1'b1;
    HostRequestSlowDown = 1'b0;
    HostFiFoFillAmt     = 32'h0;
    LocalFifoAlmostFull = 1'b0;
    RVVIStall           = 1'b0;
    cyc(2);
    check("rst_hoststall", 32'(HostStall), 32'd0);
    check("rst_reason", 32'(StallReason), 32'd0);
    check("rst_pending", 32'(PendingCount), 32'd0);
    bus_struct_reset = 1'b0;
    cyc(2);

    // Single request, ack two cycles after the pulse.
    expect_ep(2'b01, BASE);
    pulse();
    check("s1_pending_wait", 32'(PendingCount), 32'd1);
    check("s1_nostall_wait", 32'(HostStall), 32'd0);
    cyc(1);
    RVVIStall = 1'b1;
    wait_stall("s1_rise", 1'b1, 5, n);
    check("s1_ack_latency", 32'(n), 32'd1);
    check("s1_reason", 32'(StallReason), 32'd1);
    wait_stall("s1_fall", 1'b0, 1000, n);
    check("s1_hold_len", 32'(n), 32'(BASE));
    check("s1_pending_done", 32'(PendingCount), 32'd0);
    cyc(COOL);
    check("s1_cool_low", 32'(HostStall), 32'd0);
`ifdef RVVI_STALL_STATS_EN
    check("stats_cycles", StallCycles, 32'd800);
    check("stats_episodes", 32'(StallEpisodes), 32'd1);
`endif
    cyc(5);

    // Adaptive thresholds, fill changed mid-hold.
    HostFiFoFillAmt = 32'h0300_0000;
    expect_ep(2'b01, 3200);
    pulse();
    wait_stall("fill03_rise", 1'b1, 5, n);
    cyc(100);
    HostFiFoFillAmt = 32'h0;
    wait_stall("fill03_fall", 1'b0, 5000, n);
    cyc(COOL + 4);

    HostFiFoFillAmt = 32'hFF00_0000;
    expect_ep(2'b01, 51200);
    pulse();
    wait_stall("fillff_rise", 1'b1, 5, n);
    cyc(100);
    HostFiFoFillAmt = 32'h0100_0000;
    wait_stall("fillff_fall", 1'b0, 60000, n);
    check("fillff_len", 32'(n + 100), 32'd51200);
    HostFiFoFillAmt = 32'h0;
    cyc(COOL + 4);

    // Queued requests: one starts the hold, two more arrive during it.
    for (int k = 0; k < 3; k++) expect_ep(2'b01, BASE);
    pulse();
    wait_stall("q_rise", 1'b1, 5, n);
    cyc(10);
    pulse();
    cyc(10);
    pulse();
    check("q_pending_peak", 32'(PendingCount), 32'd3);
    for (int k = 0; k < 3; k++) begin
      wait_stall("q_fall", 1'b0, 1000, n);
      check("q_pending_after", 32'(PendingCount), 32'(2 - k));
      if (k < 2) begin
        wait_stall("q_next_rise", 1'b1, 100, n);
        check("q_gap", 32'(n), 32'(GAP));
      end
    end
    cyc(COOL + 4);

    // Local almost-full while the host request waits for ack.
    RVVIStall = 1'b0;
    expect_ep(2'b10, 50);
    expect_ep(2'b01, BASE);
    pulse();
    LocalFifoAlmostFull = 1'b1;
    cyc(1);
    check("lw_reason_local", 32'(StallReason), 32'd2);
    check("lw_pending_kept", 32'(PendingCount), 32'd1);
    RVVIStall = 1'b1;
    cyc(49);
    LocalFifoAlmostFull = 1'b0;
    wait_stall("lw_local_fall", 1'b0, 10, n);
    check("lw_pending_cool", 32'(PendingCount), 32'd1);
    wait_stall("lw_host_rise", 1'b1, 100, n);
    check("lw_gap", 32'(n), 32'(GAP));
    check("lw_host_reason", 32'(StallReason), 32'd1);
    check("lw_pending_hold", 32'(PendingCount), 32'd1);
    wait_stall("lw_host_fall", 1'b0, 1000, n);
    check("lw_pending_done", 32'(PendingCount), 32'd0);
    cyc(COOL + 4);

    // Local almost-full during a host hold: no preemption, no gap afterwards.
    expect_ep(2'b01, BASE);
    expect_ep(2'b10, 31);
    pulse();
    wait_stall("lh_rise", 1'b1, 5, n);
    cyc(100);
    LocalFifoAlmostFull = 1'b1;
    cyc(1);
    check("lh_not_preempted", 32'(StallReason), 32'd1);
    wait_reason("lh_to_local", 2'b10, 1000, n);
    check("lh_no_gap", 32'(HostStall), 32'd1);
    check("lh_pending", 32'(PendingCount), 32'd0);
    cyc(30);
    LocalFifoAlmostFull = 1'b0;
    wait_stall("lh_fall", 1'b0, 5, n);
    cyc(COOL + 4);

    // Ack gating, then reset in the middle of the hold.
    RVVIStall = 1'b0;
    pulse();
    for (int k = 0; k < 4; k++) begin
      cyc(25);
      check("ack_gate_low", 32'(HostStall), 32'd0);
    end
    check("ack_gate_pending", 32'(PendingCount), 32'd1);
    RVVIStall = 1'b1;
    wait_stall("ack_rise", 1'b1, 5, n);
    check("ack_latency", 32'(n), 32'd1);
    pulse();
    cyc(398);
    check("rst_mid_pending_before", 32'(PendingCount), 32'd2);
    bus_struct_reset = 1'b1;
    #1;
    check("rst_mid_stall_async", 32'(HostStall), 32'd0);
    check("rst_mid_pending", 32'(PendingCount), 32'd0);
`ifdef RVVI_STALL_STATS_EN
    check("rst_mid_stats", StallCycles, 32'd0);
`endif
    cyc(2);
    bus_struct_reset = 1'b0;
    cyc(30);
    check("post_rst_idle", 32'(HostStall), 32'd0);
    check("post_rst_pending", 32'(PendingCount), 32'd0);

    cyc(5);
    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
